neuron_update: RTL

NEURON_UPDATE -- requirements
Module: neuron_update

---
 rtl/neuron_update_pkg.sv | 26 ++
 rtl/neuron_lane.sv | 76 +++++++
 rtl/neuron_update.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/neuron_update_pkg.sv
// -----------------------------------------------------------------------------
// neuron_update_pkg
//   Shared definitions for the membrane-potential update block: default
//   widths, the update FSM state encoding and the saturation bounds of a
//   default-width membrane potential.
// -----------------------------------------------------------------------------
package neuron_update_pkg;

  localparam int N_NEURON_DEF = 256;
  localparam int ACC_W_DEF    = 13;
  localparam int VMEM_W_DEF   = 16;
  localparam int LANES_DEF    = 8;
  localparam int LEAK_W       = 8;

  // Signed range limits of a VMEM_W_DEF-bit membrane potential.
  localparam logic signed [VMEM_W_DEF-1:0] VMEM_MAX = 16'sh7fff;
  localparam logic signed [VMEM_W_DEF-1:0] VMEM_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SNAP   = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/neuron_lane.sv
// -----------------------------------------------------------------------------
// neuron_lane
//   Combinational update of one neuron for one timestep:
//     s     = sat(v + sext(acc) - zext(leak))
//     spike = (s >= threshold)
//     v_out = spike ? (mode ? sat(s - threshold) : 0) : s
//
// Ports
//   v_in    : current membrane potential (signed)
//   acc_in  : synaptic sum for this timestep (signed)
//   leak_in : per-timestep leak (unsigned)
//   thr_in  : firing threshold (signed)
//   mode_in : 0 = reset to zero on fire, 1 = subtract threshold on fire
//   v_out   : next membrane potential
//   spike   : fire flag for this timestep
// -----------------------------------------------------------------------------
module neuron_lane
  import neuron_update_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int VMEM_W = VMEM_W_DEF
) (
  input  logic signed [VMEM_W-1:0] v_in,
  input  logic signed [ACC_W-1:0]  acc_in,
  input  logic        [LEAK_W-1:0] leak_in,
  input  logic signed [VMEM_W-1:0] thr_in,
  input  logic                     mode_in,
  output logic signed [VMEM_W-1:0] v_out,
  output logic                     spike
);

  // Two guard bits cover v + acc - leak and s - threshold without overflow.
  localparam int S_W = VMEM_W + 2;

  localparam logic signed [S_W-1:0] S_MAX = (VMEM_W == VMEM_W_DEF) ? S_W'(VMEM_MAX)
                                          : {3'b000, {(VMEM_W-1){1'b1}}};
  localparam logic signed [S_W-1:0] S_MIN = (VMEM_W == VMEM_W_DEF) ? S_W'(VMEM_MIN)
                                          : {3'b111, {(VMEM_W-1){1'b0}}};

  function automatic logic signed [VMEM_W-1:0] sat(input logic signed [S_W-1:0] x);
    if (x > S_MAX) begin
      sat = S_MAX[VMEM_W-1:0];
    end else if (x < S_MIN) begin
      sat = S_MIN[VMEM_W-1:0];
    end else begin
      sat = x[VMEM_W-1:0];
    end
  endfunction

  logic signed [S_W-1:0]    v_ext;
  logic signed [S_W-1:0]    acc_ext;
  logic signed [S_W-1:0]    leak_ext;
  logic signed [S_W-1:0]    thr_ext;
  logic signed [S_W-1:0]    s_raw;
  logic signed [S_W-1:0]    s_ext;
  logic signed [S_W-1:0]    diff;
  logic signed [VMEM_W-1:0] s_sat;

  always_comb begin
    v_ext    = {{2{v_in[VMEM_W-1]}}, v_in};
    acc_ext  = {{(S_W-ACC_W){acc_in[ACC_W-1]}}, acc_in};
    leak_ext = {{(S_W-LEAK_W){1'b0}}, leak_in};
    thr_ext  = {{2{thr_in[VMEM_W-1]}}, thr_in};
    s_raw    = v_ext + acc_ext - leak_ext;
    s_sat    = sat(s_raw);
    s_ext    = {{2{s_sat[VMEM_W-1]}}, s_sat};
    diff     = s_ext - thr_ext;
    spike    = (s_sat >= thr_in);
    if (spike) begin
      v_out = mode_in ? sat(diff) : '0;
    end else begin
      v_out = s_sat;
    end
  end

endmodule

// File: rtl/neuron_update.sv
// -----------------------------------------------------------------------------
// neuron_update
//   Timestep update of N_NEURON leaky integrate-and-fire membrane potentials,
//   LANES neurons per cycle.
//
//   Handshake: start_update is a one-cycle request honoured only while busy
//   is low; the block then raises busy, snapshots its inputs, walks all
//   neuron groups and pulses done for one cycle, in which spike_out already
//   holds the new spike vector. clear_vmem is likewise honoured only in IDLE.
//
// Ports
//   clk_in, rstb  : clock, asynchronous active-low reset
//   start_update  : begin one timestep update (IDLE only)
//   accum_in      : per-neuron signed synaptic sums, captured in SNAP
//   threshold     : signed firing threshold, captured in SNAP
//   leak          : unsigned per-timestep leak, captured in SNAP
//   reset_mode    : 0 = zero on fire, 1 = subtract threshold, captured in SNAP
//   clear_vmem    : zero all potentials (IDLE only)
//   busy          : update in progress (SNAP, UPDATE, DONE)
//   done          : one-cycle pulse, spike_out valid
//   spike_out     : spike vector of the last completed timestep
//   state_dbg     : current FSM state, for observation only
// -----------------------------------------------------------------------------
module neuron_update
  import neuron_update_pkg::*;
#(
  parameter int N_NEURON = N_NEURON_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int VMEM_W   = VMEM_W_DEF,
  parameter int LANES    = LANES_DEF
) (
  input  logic                             clk_in,
  input  logic                             rstb,
  input  logic                             start_update,
  input  logic [N_NEURON-1:0][ACC_W-1:0]   accum_in,
  input  logic signed [VMEM_W-1:0]         threshold,
  input  logic [LEAK_W-1:0]                leak,
  input  logic                             reset_mode,
  input  logic                             clear_vmem,
  output logic                             busy,
  output logic                             done,
  output logic [N_NEURON-1:0]              spike_out,
  output state_e                           state_dbg
);

  localparam int N_GROUPS = N_NEURON / LANES;
  localparam int GRP_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam int IDX_W    = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(N_GROUPS - 1);

  state_e                          state_q, state_d;
  logic [GRP_W-1:0]                group_q, group_d;
  logic [N_NEURON-1:0][VMEM_W-1:0] vmem_q, vmem_d;
  logic [N_NEURON-1:0][ACC_W-1:0]  acc_snap_q, acc_snap_d;
  logic signed [VMEM_W-1:0]        thr_q, thr_d;
  logic [LEAK_W-1:0]               leak_q, leak_d;
  logic                            mode_q, mode_d;
  logic [N_NEURON-1:0]             shadow_q, shadow_d;
  logic [N_NEURON-1:0]             spike_q, spike_d;

  logic [LANES-1:0][IDX_W-1:0]     lane_idx;
  logic [LANES-1:0][VMEM_W-1:0]    lane_v_in;
  logic [LANES-1:0][ACC_W-1:0]     lane_acc;
  logic [LANES-1:0][VMEM_W-1:0]    lane_v_out;
  logic [LANES-1:0]                lane_spk;

  // Lane l of group g handles neuron g*LANES + l.
  always_comb begin
    lane_idx  = '0;
    lane_v_in = '0;
    lane_acc  = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l]  = IDX_W'(int'(group_q) * LANES + l);
      lane_v_in[l] = vmem_q[lane_idx[l]];
      lane_acc[l]  = acc_snap_q[lane_idx[l]];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    neuron_lane #(
      .ACC_W  (ACC_W),
      .VMEM_W (VMEM_W)
    ) u_lane (
      .v_in    (lane_v_in[l]),
      .acc_in  (lane_acc[l]),
      .leak_in (leak_q),
      .thr_in  (thr_q),
      .mode_in (mode_q),
      .v_out   (lane_v_out[l]),
      .spike   (lane_spk[l])
    );
  end

  always_comb begin
    state_d    = state_q;
    group_d    = group_q;
    vmem_d     = vmem_q;
    acc_snap_d = acc_snap_q;
    thr_d      = thr_q;
    leak_d     = leak_q;
    mode_d     = mode_q;
    shadow_d   = shadow_q;
    spike_d    = spike_q;

    unique case (state_q)
      IDLE: begin
        // A clear issued together with a start lands in the same edge as
        // the move to SNAP, so the update sees zeroed potentials.
        if (clear_vmem) begin
          vmem_d = '0;
        end
        if (start_update) begin
          state_d = SNAP;
        end
      end
      SNAP: begin
        acc_snap_d = accum_in;
        thr_d      = threshold;
        leak_d     = leak;
        mode_d     = reset_mode;
        group_d    = '0;
        shadow_d   = '0;
        state_d    = UPDATE;
      end
      UPDATE: begin
        for (int l = 0; l < LANES; l++) begin
          vmem_d[lane_idx[l]]   = lane_v_out[l];
          shadow_d[lane_idx[l]] = lane_spk[l];
        end
        if (group_q == LAST_GRP) begin
          // Publish including the final group's spikes on entry to DONE.
          spike_d = shadow_d;
          state_d = DONE;
        end else begin
          group_d = group_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      group_q    <= '0;
      vmem_q     <= '0;
      acc_snap_q <= '0;
      thr_q      <= '0;
      leak_q     <= '0;
      mode_q     <= 1'b0;
      shadow_q   <= '0;
      spike_q    <= '0;
    end else begin
      state_q    <= state_d;
      group_q    <= group_d;
      vmem_q     <= vmem_d;
      acc_snap_q <= acc_snap_d;
      thr_q      <= thr_d;
      leak_q     <= leak_d;
      mode_q     <= mode_d;
      shadow_q   <= shadow_d;
      spike_q    <= spike_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign spike_out = spike_q;
  assign state_dbg = state_q;

endmodule
